// File: rtl/rotary_dial_decoder.sv
// rotary_dial_decoder
//   Dial front end for the combination lock. Synchronises and debounces a raw
//   quadrature encoder and a centre push-button, decodes quadrature steps into
//   a wrapping absolute dial position and emits one-cycle step/press pulses.
//
// Ports
//   Clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   EncA/EncB  in   raw asynchronous encoder channels
//   BtnCenter  in   raw asynchronous centre button, 1 = pressed
//   Count      out  dial position 0..POS_MAX
//   Right      out  one-cycle pulse, clockwise detent completed
//   Left       out  one-cycle pulse, counter-clockwise detent completed
//   Center     out  one-cycle pulse on debounced button press
//   Error      out  sticky, illegal quadrature transition seen
//   Armed      out  start-up settle period complete
module rotary_dial_decoder #(
    parameter int POS_MAX          = 19,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int EDGES_PER_DETENT = 4
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       EncA,
    input  logic       EncB,
    input  logic       BtnCenter,
    output logic [4:0] Count,
    output logic       Right,
    output logic       Left,
    output logic       Center,
    output logic       Error,
    output logic       Armed
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW  = $clog2(DEBOUNCE_CYCLES + 3);

    localparam logic [DBW-1:0]    DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0]     ARM_LAST = AW'(DEBOUNCE_CYCLES + 2);
    localparam logic [4:0]        POS_TOP  = 5'(POS_MAX);
    localparam logic signed [3:0] ACC_TOP  = 4'(EDGES_PER_DETENT - 1);
    localparam logic signed [3:0] ACC_BOT  = -ACC_TOP;

    // Bit order for the per-signal vectors: {A, B, button}
    logic [2:0]     s1, s2;
    logic [2:0]     filt;
    logic [DBW-1:0] db_cnt [3];
    logic [AW-1:0]  arm_cnt;

    logic [1:0]        prev_ab;
    logic              btn_prev;
    logic signed [3:0] acc;

    logic [1:0]        ab;
    logic [1:0]        dir;
    logic signed [3:0] acc_nx;
    logic [4:0]        count_nx;
    logic              right_nx, left_nx, center_nx, error_nx;

    // Position of a quadrature state along the clockwise cycle 00->01->11->10.
    // The modulo-4 difference of two positions gives the transition type.
    function automatic logic [1:0] quad_pos(input logic [1:0] v);
        case (v)
            2'b00:   quad_pos = 2'd0;
            2'b01:   quad_pos = 2'd1;
            2'b11:   quad_pos = 2'd2;
            default: quad_pos = 2'd3;
        endcase
    endfunction

    // ---- synchroniser ----
    always_ff @(posedge Clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {EncA, EncB, BtnCenter};
            s2 <= s1;
        end
    end

    // ---- debounce filters and arming ----
    // Until armed the filters track the synchronisers directly, so whatever
    // level the inputs rest at after reset is adopted without producing steps.
    always_ff @(posedge Clk) begin
        if (reset) begin
            filt    <= '0;
            arm_cnt <= '0;
            Armed   <= 1'b0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            if (!Armed) begin
                if (arm_cnt == ARM_LAST) Armed <= 1'b1;
                else                     arm_cnt <= arm_cnt + 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!Armed) begin
                    filt[i]   <= s2[i];
                    db_cnt[i] <= '0;
                end else if (s2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ---- quadrature decode and button edge ----
    assign ab  = filt[2:1];
    assign dir = quad_pos(ab) - quad_pos(prev_ab);

    always_comb begin
        acc_nx    = acc;
        count_nx  = Count;
        right_nx  = 1'b0;
        left_nx   = 1'b0;
        error_nx  = Error;
        center_nx = Armed & filt[0] & ~btn_prev;
        if (Armed) begin
            case (dir)
                2'd1: begin
                    if (acc == ACC_TOP) begin
                        acc_nx   = '0;
                        right_nx = 1'b1;
                        count_nx = (Count == POS_TOP) ? 5'd0 : Count + 5'd1;
                    end else begin
                        acc_nx = acc + 4'sd1;
                    end
                end
                2'd3: begin
                    if (acc == ACC_BOT) begin
                        acc_nx   = '0;
                        left_nx  = 1'b1;
                        count_nx = (Count == 5'd0) ? POS_TOP : Count - 5'd1;
                    end else begin
                        acc_nx = acc - 4'sd1;
                    end
                end
                2'd2: begin
                    // Both channels moved at once: direction unknown.
                    error_nx = 1'b1;
                    acc_nx   = '0;
                end
                default: ;
            endcase
        end
    end

    // ---- output registers ----
    always_ff @(posedge Clk) begin
        if (reset) begin
            prev_ab  <= '0;
            btn_prev <= 1'b0;
            acc      <= '0;
            Count    <= '0;
            Right    <= 1'b0;
            Left     <= 1'b0;
            Center   <= 1'b0;
            Error    <= 1'b0;
        end else begin
            prev_ab  <= ab;
            btn_prev <= filt[0];
            acc      <= acc_nx;
            Count    <= count_nx;
            Right    <= right_nx;
            Left     <= left_nx;
            Center   <= center_nx;
            Error    <= error_nx;
        end
    end

endmodule

// File: doc/rotary_dial_decoder.md
Name: rotary_dial_decoder

Overview:
Front end that produces the dial inputs consumed by the combination lock FSM. It synchronises and debounces a raw quadrature encoder (EncA/EncB) and a raw centre push-button, and tracks an absolute dial position that wraps. It emits single-cycle Right/Left step pulses alongside the updated Count, and a single-cycle Center press pulse. All outputs are Clk-domain registers and can drive the lock FSM directly.

Parameters:
POS_MAX, 19, highest dial position; Count runs 0..POS_MAX and wraps (1 <= POS_MAX <= 31)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates (>= 1)
EDGES_PER_DETENT, 4, legal quadrature transitions per dial step (1, 2 or 4)

Ports:
Clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
EncA  input  1  raw asynchronous encoder channel A
EncB  input  1  raw asynchronous encoder channel B
BtnCenter  input  1  raw asynchronous centre button, 1 = pressed
Count  output  5  dial position 0..POS_MAX
Right  output  1  one-cycle pulse: clockwise step taken this cycle
Left  output  1  one-cycle pulse: counter-clockwise step taken this cycle
Center  output  1  one-cycle pulse on debounced press
Error  output  1  sticky: illegal quadrature transition seen
Armed  output  1  1 once the start-up settle period is complete

Behaviour:
- Interface: reset reset, synchronous, active-high; clock Clk.
- Reset values: Count=0, Right=0, Left=0, Center=0, Error=0, Armed=0. Sync flops, filters, debounce counters, prev_ab and the detent accumulator are all cleared.
- Synchroniser: each raw input passes through 2 flops (s1, s2).
- Debounce, per signal:
  - The counter increments each cycle that s2 != filt, and clears to 0 when s2 == filt.
  - When the counter would reach DEBOUNCE_CYCLES, filt <= s2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches filt.
- Arming:
  - While Armed=0: filt <= s2 and prev_ab <= {filtA,filtB} every cycle. No steps, no Center pulse, no Error.
  - An arm counter sets Armed=1 after DEBOUNCE_CYCLES+3 cycles out of reset. Armed stays 1 until the next reset.
- Quadrature decode (Armed=1), comparing ab={filtA,filtB} with prev_ab each cycle; prev_ab <= ab:
  - Clockwise sequence: 00->01->11->10->00. Each CW transition adds 1 to the signed accumulator acc; each CCW transition subtracts 1.
  - ab == prev_ab: no change.
  - Both bits change: illegal. Error <= 1, acc <= 0, Count unchanged, no pulse.
  - acc reaches +EDGES_PER_DETENT: acc <= 0, Count <= (Count==POS_MAX) ? 0 : Count+1, Right=1 for that cycle.
  - acc reaches -EDGES_PER_DETENT: acc <= 0, Count <= (Count==0) ? POS_MAX : Count-1, Left=1 for that cycle.
  - Direction reversal mid-detent unwinds acc with no output.
- Pulse alignment: Right/Left assert in the same cycle Count takes its new value. Right and Left are never both 1.
- Latency: outputs update on the (DEBOUNCE_CYCLES+2)th rising edge after the edge on which s1 first captures the final raw change.
- Center:
  - Center=1 for one cycle on a 0->1 change of the filtered button.
  - No pulse on release. A held button gives exactly one pulse.
  - Center is independent of, and may coincide with, Right/Left.
- Error: clears only on reset; decoding continues after an error.
- Reset mid-operation: everything returns to reset values on the next edge, Armed drops to 0, and any partial detent is discarded.

Test Plan:
- Reset, raw inputs idle at A=B=1 -> Armed=1 after 7 cycles (DEBOUNCE_CYCLES=4), Count=0, no pulses, Error=0.
- After arming, one full CW cycle 11->10->00->01->11, each phase held 10 cycles -> exactly one Right pulse and Count=1. Pulse lands 6 cycles after s1 captures the final phase.
- From Count=0, one CCW detent -> Count=19 with one Left pulse. From Count=19, one CW detent -> Count=0 with one Right pulse.
- Half detent CW (2 transitions) then back CCW -> Count unchanged, no pulses. A 3-cycle glitch on EncA -> ignored entirely.
- Jump 11->00 held 10 cycles -> Error=1, Count unchanged. A following legal CW detent still increments Count. reset -> Error=0.
- BtnCenter bounce (1,0,1 in 2-cycle bursts), then steady 1 for 20 cycles, then release -> exactly one Center pulse. Assert reset during a half detent -> Count=0, Armed=0, no step pulse afterwards.
